// File: rtl/flags_register.sv
// flags_register: two-stage {C,N,V,Z} flag pipeline with forwarding, stall, flush and direct load
module flags_register (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Valid_In,
    input  logic       S_Bit,
    input  logic       Cond_Pass,
    input  logic [3:0] ALU_Flags,
    input  logic       Keep_C,
    input  logic       Keep_V,
    input  logic       Load_En,
    input  logic [3:0] Load_Data,
    input  logic       Stall,
    input  logic       Flush,
    output logic [3:0] Flags,
    output logic [3:0] Flags_Fwd,
    output logic       Pending,
    output logic [7:0] Commit_Cnt
);
    typedef enum logic {EMPTY, PEND} state_t;
    state_t state, state_nxt;
    logic [3:0] pend_data, cand;
    logic upd, hold, commit, capture;
    always_ff @(posedge Clk)
        state <= Reset ? EMPTY : state_nxt;
    always_comb begin
        hold      = (state == PEND) && Stall;
        upd       = Valid_In && S_Bit && Cond_Pass;
        state_nxt = (Load_En || Flush) ? EMPTY : (hold || upd) ? PEND : EMPTY;
    end
    always_comb begin
        Pending   = (state == PEND);
        Flags_Fwd = Pending ? pend_data : Flags;
        cand      = {Keep_C ? Flags_Fwd[3] : ALU_Flags[3], ALU_Flags[2],
                     Keep_V ? Flags_Fwd[1] : ALU_Flags[1], ALU_Flags[0]};
        commit    = Pending && !Stall && !Load_En && !Flush;
        capture   = upd && !hold && !Load_En && !Flush;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Flags      <= 4'b0000;
            pend_data  <= 4'b0000;
            Commit_Cnt <= 8'd0;
        end else begin
            if (Load_En)
                Flags <= Load_Data;
            else if (commit)
                Flags <= pend_data;
            if (capture)
                pend_data <= cand;
            if (commit && Commit_Cnt != 8'hff)
                Commit_Cnt <= Commit_Cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_flags_register.sv
// tb_flags_register: directed checks of the flag pipeline
module tb_flags_register;
    logic       Clk = 0, Reset, Valid_In, S_Bit, Cond_Pass, Keep_C, Keep_V;
    logic       Load_En, Stall, Flush;
    logic [3:0] ALU_Flags, Load_Data, Flags, Flags_Fwd;
    logic       Pending;
    logic [7:0] Commit_Cnt;
    int compared = 0, mismatched = 0;

    flags_register dut (
        .Clk(Clk), .Reset(Reset), .Valid_In(Valid_In), .S_Bit(S_Bit),
        .Cond_Pass(Cond_Pass), .ALU_Flags(ALU_Flags), .Keep_C(Keep_C),
        .Keep_V(Keep_V), .Load_En(Load_En), .Load_Data(Load_Data),
        .Stall(Stall), .Flush(Flush), .Flags(Flags), .Flags_Fwd(Flags_Fwd),
        .Pending(Pending), .Commit_Cnt(Commit_Cnt)
    );

    always #5 Clk = ~Clk;

    task automatic idle();
        Reset = 0; Valid_In = 0; S_Bit = 0; Cond_Pass = 0; ALU_Flags = 0;
        Keep_C = 0; Keep_V = 0; Load_En = 0; Load_Data = 0; Stall = 0; Flush = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_upd(input logic [3:0] alu);
        Valid_In = 1; S_Bit = 1; Cond_Pass = 1; ALU_Flags = alu;
    endtask

    task automatic test_reset();
        idle(); Reset = 1; Load_En = 1; Load_Data = 4'hf; set_upd(4'hf);
        step(); idle();
        compared++; if (Flags !== 4'b0000) begin mismatched++; $display("FAIL reset_flags got %b want 0000", Flags); end
        compared++; if (Pending !== 1'b0) begin mismatched++; $display("FAIL reset_pending got %b want 0", Pending); end
        compared++; if (Flags_Fwd !== 4'b0000) begin mismatched++; $display("FAIL reset_fwd got %b want 0000", Flags_Fwd); end
        compared++; if (Commit_Cnt !== 8'd0) begin mismatched++; $display("FAIL reset_cnt got %0d want 0", Commit_Cnt); end
    endtask

    task automatic test_basic();
        set_upd(4'b0101); step(); idle();
        compared++; if (Pending !== 1'b1) begin mismatched++; $display("FAIL basic_pend got %b want 1", Pending); end
        compared++; if (Flags_Fwd !== 4'b0101) begin mismatched++; $display("FAIL basic_fwd got %b want 0101", Flags_Fwd); end
        compared++; if (Flags !== 4'b0000) begin mismatched++; $display("FAIL basic_flags1 got %b want 0000", Flags); end
        step();
        compared++; if (Flags !== 4'b0101) begin mismatched++; $display("FAIL basic_flags2 got %b want 0101", Flags); end
        compared++; if (Pending !== 1'b0) begin mismatched++; $display("FAIL basic_pend2 got %b want 0", Pending); end
        compared++; if (Commit_Cnt !== 8'd1) begin mismatched++; $display("FAIL basic_cnt got %0d want 1", Commit_Cnt); end
    endtask

    task automatic test_keep();
        Load_En = 1; Load_Data = 4'b1000; step(); idle();
        compared++; if (Flags !== 4'b1000 || Commit_Cnt !== 8'd1) begin mismatched++; $display("FAIL keep_load got %b/%0d want 1000/1", Flags, Commit_Cnt); end
        set_upd(4'b0011); Keep_C = 1; step(); idle(); step();
        compared++; if (Flags !== 4'b1011) begin mismatched++; $display("FAIL keep_flags got %b want 1011", Flags); end
        compared++; if (Commit_Cnt !== 8'd2) begin mismatched++; $display("FAIL keep_cnt got %0d want 2", Commit_Cnt); end
    endtask

    task automatic test_stall();
        set_upd(4'b0001); step(); idle();
        Stall = 1; set_upd(4'b1110);
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (Flags !== 4'b1011 || Flags_Fwd !== 4'b0001 || Pending !== 1'b1)
                begin mismatched++; $display("FAIL stall_hold%0d got %b/%b/%b want 1011/0001/1", i, Flags, Flags_Fwd, Pending); end
        end
        idle(); step();
        compared++; if (Flags !== 4'b0001 || Pending !== 1'b0) begin mismatched++; $display("FAIL stall_commit got %b/%b want 0001/0", Flags, Pending); end
        compared++; if (Commit_Cnt !== 8'd3) begin mismatched++; $display("FAIL stall_cnt got %0d want 3", Commit_Cnt); end
    endtask

    task automatic test_load();
        set_upd(4'b0100); step();
        set_upd(4'b0111); Load_En = 1; Load_Data = 4'b1110; step(); idle();
        compared++; if (Flags !== 4'b1110 || Pending !== 1'b0) begin mismatched++; $display("FAIL load_flags got %b/%b want 1110/0", Flags, Pending); end
        compared++; if (Commit_Cnt !== 8'd3) begin mismatched++; $display("FAIL load_cnt got %0d want 3", Commit_Cnt); end
        step();
        compared++; if (Flags !== 4'b1110) begin mismatched++; $display("FAIL load_after got %b want 1110", Flags); end
    endtask

    task automatic test_cond_flush();
        set_upd(4'b1111); Cond_Pass = 0; step(); idle();
        compared++; if (Pending !== 1'b0 || Flags !== 4'b1110 || Commit_Cnt !== 8'd3)
            begin mismatched++; $display("FAIL cond_fail got %b/%b/%0d want 0/1110/3", Pending, Flags, Commit_Cnt); end
        set_upd(4'b0010); step();
        Flush = 1; set_upd(4'b0110); step(); idle();
        compared++; if (Pending !== 1'b0 || Flags !== 4'b1110 || Flags_Fwd !== 4'b1110)
            begin mismatched++; $display("FAIL flush got %b/%b/%b want 0/1110/1110", Pending, Flags, Flags_Fwd); end
        step();
        compared++; if (Flags !== 4'b1110 || Commit_Cnt !== 8'd3)
            begin mismatched++; $display("FAIL flush_after got %b/%0d want 1110/3", Flags, Commit_Cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        int exp_cnt;
        for (int k = 1; k <= 300; k++) begin
            set_upd(4'(k)); step();
            exp_cnt = (3 + k - 1 > 255) ? 255 : 3 + k - 1;
            compared++; if (Pending !== 1'b1 || Commit_Cnt !== 8'(exp_cnt))
                begin mismatched++; $display("FAIL b2b_%0d got %b/%0d want 1/%0d", k, Pending, Commit_Cnt, exp_cnt); end
            if (k > 1) begin
                compared++; if (Flags !== prev) begin mismatched++; $display("FAIL b2b_flags_%0d got %b want %b", k, Flags, prev); end
            end
            prev = 4'(k);
        end
        idle(); step();
        compared++; if (Pending !== 1'b0 || Flags !== 4'(300) || Commit_Cnt !== 8'd255)
            begin mismatched++; $display("FAIL b2b_end got %b/%b/%0d want 0/1100/255", Pending, Flags, Commit_Cnt); end
    endtask

    task automatic test_reset_mid();
        set_upd(4'b0110); step(); idle();
        Reset = 1; Load_En = 1; Load_Data = 4'b1111; Flush = 1; step(); idle();
        compared++; if (Pending !== 1'b0 || Flags !== 4'b0000 || Commit_Cnt !== 8'd0 || Flags_Fwd !== 4'b0000)
            begin mismatched++; $display("FAIL reset_mid got %b/%b/%0d/%b want 0/0000/0/0000", Pending, Flags, Commit_Cnt, Flags_Fwd); end
        step();
        compared++; if (Flags !== 4'b0000) begin mismatched++; $display("FAIL reset_mid_after got %b want 0000", Flags); end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_keep();
        test_stall();
        test_load();
        test_cond_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/flags_register.md
FLAGS_REGISTER -- requirements
Module: flags_register

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous and active-high, sampled on the Clk rising edge.
REQ-003 SHALL have port Valid_In, input, 1 bit: an executing instruction is present this cycle.
REQ-004 SHALL have port S_Bit, input, 1 bit: the executing instruction requests a flag update.
REQ-005 SHALL have port Cond_Pass, input, 1 bit: condition-check result for the executing instruction.
REQ-006 SHALL have port ALU_Flags, input, 4 bits: {C,N,V,Z} from the ALU; bit3=C, bit2=N, bit1=V, bit0=Z.
REQ-007 SHALL have port Keep_C, input, 1 bit: preserve C (logical ops without shifter carry).
REQ-008 SHALL have port Keep_V, input, 1 bit: preserve V.
REQ-009 SHALL have port Load_En, input, 1 bit: direct flag write (MSR-style).
REQ-010 SHALL have port Load_Data, input, 4 bits: value for the direct write, same {C,N,V,Z} order.
REQ-011 SHALL have port Stall, input, 1 bit: holds the commit stage.
REQ-012 SHALL have port Flush, input, 1 bit: squashes the pending update.
REQ-013 SHALL have port Flags, output, 4 bits: architectural flags, registered, {C,N,V,Z}.
REQ-014 SHALL have port Flags_Fwd, output, 4 bits: forwarded flags for the condition check, combinational.
REQ-015 SHALL have port Pending, output, 1 bit: a flag update is awaiting commit.
REQ-016 SHALL have port Commit_Cnt, output, 8 bits: saturating count of committed ALU updates.

Function
REQ-017 SHALL implement a two-state FSM: EMPTY and PEND; the pending register holds Pend_Data[3:0].
REQ-018 SHALL define Upd as Valid_In & S_Bit & Cond_Pass.
REQ-019 SHALL form the candidate value: C = Keep_C ? Flags_Fwd[3] : ALU_Flags[3]; V = Keep_V ? Flags_Fwd[1] : ALU_Flags[1]; N and Z always come from ALU_Flags.
REQ-020 SHALL drive Flags_Fwd as Pend_Data in PEND and as Flags in EMPTY; there is no bypass of same-cycle ALU_Flags.
REQ-021 SHALL transition EMPTY -> PEND when Upd=1 and no Load_En/Flush; the candidate is captured into Pend_Data.
REQ-022 SHALL, in PEND with Stall=0: Flags <= Pend_Data, Commit_Cnt increments (saturating at 255), and the FSM goes to PEND with new Pend_Data if Upd=1, otherwise to EMPTY.
REQ-023 SHALL, in PEND with Stall=1: hold Pend_Data, Flags and Commit_Cnt; Upd is ignored.
REQ-024 SHALL give Load_En the highest priority after Reset: Flags <= Load_Data, FSM -> EMPTY, pending squashed, Upd ignored, and Commit_Cnt unchanged.
REQ-025 SHALL, on Flush with Load_En=0: go to EMPTY with the pending update discarded and Flags unchanged, and ignore a same-cycle Upd.
REQ-026 SHALL hold Flags unchanged when Upd=0 in EMPTY; a failed condition (Cond_Pass=0) never alters state.
REQ-027 SHALL drive Pending=1 exactly when the FSM is in PEND.
REQ-028 SHALL give a flag-setting instruction a latency of 2 edges to Flags and 1 edge to Flags_Fwd, when there is no stall.
REQ-029 SHALL accept back-to-back updates without bubbles.

Reset
REQ-030 SHALL, on Reset=1 at a Clk edge: Flags=4'b0000, FSM=EMPTY, Pend_Data=0, Commit_Cnt=0; therefore Pending=0 and Flags_Fwd=0.
REQ-031 SHALL give Reset priority over Load_En, Flush, Stall and Upd; Reset mid-PEND discards the pending update.

Verification
REQ-032 SHALL cover: Reset, then Upd with ALU_Flags=4'b0101 -> after edge 1 Pending=1 and Flags_Fwd=0101 with Flags=0000; after edge 2 Flags=0101, Pending=0, Commit_Cnt=1.
REQ-033 SHALL cover: Flags=1000, Upd with ALU_Flags=0011, Keep_C=1, Keep_V=0 -> committed Flags=1011.
REQ-034 SHALL cover: PEND (0001) with Stall=1 for 3 cycles -> Flags unchanged and Flags_Fwd=0001 throughout; the commit occurs on the first edge with Stall=0.
REQ-035 SHALL cover: PEND plus Load_En with Load_Data=1110 plus Upd in the same cycle -> Flags=1110, Pending=0, Commit_Cnt unchanged.
REQ-036 SHALL cover: Cond_Pass=0 with S_Bit=1, Valid_In=1 -> no state change; Flush in PEND -> Pending=0 and Flags unchanged.
REQ-037 SHALL cover: 300 back-to-back updates -> Commit_Cnt saturates at 255 and Pending stays 1 until the updates stop.
